// File: rtl/test_pattern_gen.sv
// Multi-mode video test-pattern generator with camera-style line/frame timing.
// Define TPG_BORDER_EN to force a one-pixel all-ones border around the active area.
module test_pattern_gen #(
  parameter int unsigned PIXEL_W     = 10,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 160,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_BLANK     = 45,
  parameter int unsigned NUM_BARS    = 8,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] solid_level,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               line_valid,
  output logic               frame_valid,
  output logic               frame_start,
  output logic [15:0]        frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;
  localparam int unsigned BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned IW      = $clog2(NUM_BARS);
  localparam int unsigned MAX_LVL = (2 ** PIXEL_W) - 1;
  localparam logic [PIXEL_W-1:0] STEP     = PIXEL_W'(MAX_LVL / (NUM_BARS - 1));
  localparam logic [PIXEL_W-1:0] ALL_ONES = PIXEL_W'(MAX_LVL);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  logic [BPW-1:0]     bar_pix_q, bar_pix_d;
  logic [IW-1:0]      bar_idx_q, bar_idx_d;
  logic [1:0]         mode_q;
  logic [PIXEL_W-1:0] level_q;
  logic [PIXEL_W-1:0] fidx_q;
  logic [PIXEL_W-1:0] pixel_q, pixel_d;
  logic               line_valid_q, line_valid_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_start_q, frame_start_d;
  logic [15:0]        frame_count_q;

  logic               h_act, v_act, active;
  logic [1:0]         mode_eff;
  logic [PIXEL_W-1:0] level_eff, fidx_eff, bar_level;

  // Frame FSM and raster counters; a disabled wrap point returns to IDLE at (0,0)
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (h_cnt_q == HW'(H_TOTAL - 1)) begin
          h_cnt_d = '0;
          if (v_cnt_q == VW'(V_TOTAL - 1)) begin
            v_cnt_d = '0;
            if (!enable) state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bar index tracks h_cnt / BAR_W incrementally, saturating on the last bar
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (h_cnt_d == '0) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (bar_pix_q == BPW'(BAR_W - 1)) begin
      bar_pix_d = '0;
      if (bar_idx_q != IW'(NUM_BARS - 1)) bar_idx_d = bar_idx_q + IW'(1);
    end else begin
      bar_pix_d = bar_pix_q + BPW'(1);
    end
  end

  // Pixel and timing outputs; at (0,0) the live inputs stand in for the latches
  always_comb begin
    frame_start_d = (state_q == RUN) && (h_cnt_q == '0) && (v_cnt_q == '0);
    h_act         = h_cnt_q < HW'(H_ACTIVE);
    v_act         = v_cnt_q < VW'(V_ACTIVE);
    active        = (state_q == RUN) && h_act && v_act;
    mode_eff      = frame_start_d ? mode : mode_q;
    level_eff     = frame_start_d ? solid_level : level_q;
    fidx_eff      = frame_start_d ? PIXEL_W'(frame_count_q) : fidx_q;
    bar_level     = (bar_idx_q == IW'(NUM_BARS - 1)) ? ALL_ONES : PIXEL_W'(bar_idx_q) * STEP;
    line_valid_d  = active;
    frame_valid_d = (state_q == RUN) && v_act;
    pixel_d       = '0;
    if (active) begin
      case (mode_eff)
        2'd0:    pixel_d = bar_level;
        2'd1:    pixel_d = PIXEL_W'(h_cnt_q) + fidx_eff;
        2'd2:    pixel_d = {PIXEL_W{h_cnt_q[CHECK_SHIFT] ^ v_cnt_q[CHECK_SHIFT] ^ fidx_eff[0]}};
        default: pixel_d = level_eff;
      endcase
`ifdef TPG_BORDER_EN
      if (h_cnt_q == '0 || h_cnt_q == HW'(H_ACTIVE - 1) ||
          v_cnt_q == '0 || v_cnt_q == VW'(V_ACTIVE - 1)) begin
        pixel_d = ALL_ONES;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bar_pix_q     <= '0;
      bar_idx_q     <= '0;
      mode_q        <= '0;
      level_q       <= '0;
      fidx_q        <= '0;
      pixel_q       <= '0;
      line_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bar_pix_q     <= bar_pix_d;
      bar_idx_q     <= bar_idx_d;
      pixel_q       <= pixel_d;
      line_valid_q  <= line_valid_d;
      frame_valid_q <= frame_valid_d;
      frame_start_q <= frame_start_d;
      if (frame_start_d) begin
        mode_q        <= mode;
        level_q       <= solid_level;
        fidx_q        <= PIXEL_W'(frame_count_q);
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign pixel_out   = pixel_q;
  assign line_valid  = line_valid_q;
  assign frame_valid = frame_valid_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: stimulus queues expected pixels and
// frame-start events, a negedge monitor pops and compares them.
module tb_test_pattern_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  mode;
  logic [9:0]  solid_level;
  logic [9:0]  pixel_out;
  logic        line_valid;
  logic        frame_valid;
  logic        frame_start;
  logic [15:0] frame_count;

  test_pattern_gen #(
    .PIXEL_W(10), .H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(4), .V_BLANK(2),
    .NUM_BARS(4), .CHECK_SHIFT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .solid_level(solid_level), .pixel_out(pixel_out), .line_valid(line_valid),
    .frame_valid(frame_valid), .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
  } fs_exp_t;

  fs_exp_t fs_q[$];
  int      pix_q[$];
  int      checks = 0;
  int      errors = 0;
  int      modes[7] = '{0, 1, 1, 2, 2, 0, 3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_pix(input int m, input int lvl, input int fidx, input int h, input int v);
    int bar_lut[4] = '{0, 341, 682, 1023};
    int p;
    case (m)
      0:       p = bar_lut[h / 4];
      1:       p = (h + fidx) % 1024;
      2:       p = (((h / 4) + (v / 4) + fidx) % 2 == 1) ? 1023 : 0;
      default: p = lvl;
    endcase
`ifdef TPG_BORDER_EN
    if (h == 0 || h == 15 || v == 0 || v == 3) p = 1023;
`endif
    return p;
  endfunction

  task automatic push_frame(input int m, input int lvl, input int fidx);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 16; h++)
        pix_q.push_back(exp_pix(m, lvl, fidx, h, v));
  endtask

  task automatic push_fs(input int c, input int n);
    fs_exp_t e;
    e.cyc = c;
    e.cnt = n;
    fs_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_quiet(input string name, input int fc);
    chk({name, "_pixel"}, int'(pixel_out), 0);
    chk({name, "_line_valid"}, int'(line_valid), 0);
    chk({name, "_frame_valid"}, int'(frame_valid), 0);
    chk({name, "_frame_start"}, int'(frame_start), 0);
    chk({name, "_frame_count"}, int'(frame_count), fc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel or a frame start
  initial begin : monitor
    int      lv_cnt;
    int      fv_cnt;
    logic    prev_fv;
    int      e_pix;
    fs_exp_t e_fs;
    lv_cnt  = 0;
    fv_cnt  = 0;
    prev_fv = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        lv_cnt  = 0;
        fv_cnt  = 0;
        prev_fv = 1'b0;
      end else begin
        if (line_valid) begin
          lv_cnt++;
          if (pix_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_unexpected: got pixel %0d expected no active pixel (cycle %0d)", pixel_out, cyc);
          end else begin
            e_pix = pix_q.pop_front();
            chk("pixel", int'(pixel_out), e_pix);
          end
        end else begin
          chk("pixel_blank", int'(pixel_out), 0);
        end
        if (frame_valid) fv_cnt++;
        if (frame_start) begin
          if (fs_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_start_unexpected: got pulse expected none (cycle %0d)", cyc);
          end else begin
            e_fs = fs_q.pop_front();
            chk("frame_start_cycle", cyc, e_fs.cyc);
            chk("frame_count", int'(frame_count), e_fs.cnt);
            chk("frame_start_fv", int'(frame_valid), 1);
          end
        end
        if (prev_fv && !frame_valid) begin
          chk("line_valid_per_frame", lv_cnt, 64);
          chk("frame_valid_per_frame", fv_cnt, 80);
          lv_cnt = 0;
          fv_cnt = 0;
        end
        prev_fv = frame_valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin : stimulus
    int fs0;
    int s;
    int x;
    reset_n     = 1'b0;
    enable      = 1'b0;
    mode        = 2'd0;
    solid_level = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset", 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("idle", 0);

    // Seven back-to-back frames; each next mode is changed at clock 30 of the current one
    mode        = 2'(modes[0]);
    solid_level = 10'h155;
    enable      = 1'b1;
    fs0         = cyc + 2;
    push_fs(fs0, 1);
    push_frame(modes[0], 'h155, 0);
    for (int k = 0; k < 7; k++) begin
      s = fs0 + 120 * k;
      if (k < 6) begin
        wait_until(s + 30);
        mode = 2'(modes[k + 1]);
        push_frame(modes[k + 1], 'h155, k + 1);
        push_fs(s + 120, k + 2);
      end else begin
        wait_until(s + 50);
        enable = 1'b0;
      end
    end

    // Frame completes despite the mid-frame disable, then everything holds quiet
    s = fs0 + 720;
    wait_until(s + 125);
    chk_quiet("after_disable", 7);
    wait_until(s + 140);
    chk_quiet("idle_hold", 7);

    x           = cyc;
    mode        = 2'd1;
    enable      = 1'b1;
    push_fs(x + 2, 8);
    push_frame(1, 'h155, 7);

    // Asynchronous reset in the middle of the restarted frame
    wait_until(x + 2 + 70);
    reset_n = 1'b0;
    #1;
    chk_quiet("async_reset", 0);
    pix_q.delete();
    fs_q.delete();
    mode        = 2'd3;
    solid_level = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    x       = cyc;
    reset_n = 1'b1;
    push_fs(x + 2, 1);
    push_frame(3, 0, 0);
    wait_until(x + 2 + 20);
    enable = 1'b0;
    wait_until(x + 2 + 125);
    chk_quiet("final_idle", 1);
    chk("pixels_left", pix_q.size(), 0);
    chk("frame_starts_left", fs_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
